// File: rtl/dm_access_pkg.sv
// rtl/dm_access_pkg.sv - shared encodings for the data-memory access controller
package dm_access_pkg;

    localparam logic [1:0] WORD = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] BYTE = 2'b10;

    localparam logic CPU = 1'b0;
    localparam logic LD  = 1'b1;

    typedef enum logic [2:0] {IDLE, RD, WAIT, MERGE, WR, RESP} state_t;

endpackage

// File: rtl/dm_lane_merge.sv
// rtl/dm_lane_merge.sv - sub-word store merge and load extract/extend for a 32-bit word
module dm_lane_merge
    import dm_access_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [31:0] rd_word,
    input  logic [1:0]  ls_bit,
    input  logic [1:0]  offset,
    input  logic        ext_op,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v    = offset[1] ? rd_word[31:16] : rd_word[15:0];
        byte_v    = rd_word[{offset, 3'b000} +: 8];
        merged    = new_data;
        extracted = rd_word;
        case (ls_bit)
            HALF: begin
                merged = old_word;
                if (offset[1]) merged[31:16] = new_data[15:0];
                else           merged[15:0]  = new_data[15:0];
                extracted = {{16{ext_op & half_v[15]}}, half_v};
            end
            BYTE: begin
                merged = old_word;
                merged[{offset, 3'b000} +: 8] = new_data[7:0];
                extracted = {{24{ext_op & byte_v[7]}}, byte_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - CPU/loader arbiter and sequencer for a single-port word SRAM
// Optional misaligned-access trap: define DM_ACCESS_CTRL_MISALIGN_TRAP_EN.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int READ_LAT      = 1,
    parameter int LD_STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [1:0]        cpu_ls_bit,
    input  logic              cpu_ext_op,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
`ifdef DM_ACCESS_CTRL_MISALIGN_TRAP_EN
    output logic              cpu_misalign,
`endif
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic [31:0]       ld_rdata,
    output logic              ld_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int SW = $clog2(LD_STARVE_MAX + 1);
    localparam logic [1:0] WAIT_INIT = 2'(READ_LAT - 1);

    state_t            state, next_state;
    logic              id_q, we_q, ext_q, mis_q;
    logic [1:0]        ls_q, off_q, wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, old_q, merged, extracted;
    logic [SW-1:0]     starve_cnt;

    logic              grant_ld, grant_cpu, g_we, g_ext, misalign;
    logic [1:0]        g_ls, g_off;
    logic [ADDR_W-1:0] g_addr;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[31:ADDR_W+2];

    dm_lane_merge u_lane (
        .old_word  (old_q),
        .new_data  (wdata_q),
        .rd_word   (mem_rdata),
        .ls_bit    (ls_q),
        .offset    (off_q),
        .ext_op    (ext_q),
        .merged    (merged),
        .extracted (extracted)
    );

    always_comb begin
        grant_ld  = ld_req & (~cpu_req | (starve_cnt == SW'(LD_STARVE_MAX)));
        grant_cpu = cpu_req & ~grant_ld;
        g_we      = grant_ld ? ld_we : cpu_we;
        g_ext     = grant_ld ? 1'b0 : cpu_ext_op;
        g_ls      = (grant_ld || cpu_ls_bit == 2'b11) ? WORD : cpu_ls_bit;
        g_off     = grant_ld ? 2'b00 : cpu_addr[1:0];
        g_addr    = grant_ld ? ld_addr : cpu_addr[ADDR_W+1:2];
        misalign  = 1'b0;
`ifdef DM_ACCESS_CTRL_MISALIGN_TRAP_EN
        misalign  = grant_cpu & (((g_ls == HALF) & g_off[0]) | ((g_ls == WORD) & (g_off != 2'b00)));
`endif
        next_state = state;
        case (state)
            // Word stores also pass through MERGE so every store issues WR from latched state.
            IDLE:  if (grant_cpu || grant_ld)
                       next_state = misalign ? RESP : ((g_we && g_ls == WORD) ? MERGE : RD);
            RD:    next_state = WAIT;
            WAIT:  if (wait_cnt == 2'd0) next_state = we_q ? MERGE : RESP;
            MERGE: next_state = WR;
            WR:    next_state = RESP;
            RESP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            id_q       <= CPU;
            we_q       <= 1'b0;
            ext_q      <= 1'b0;
            mis_q      <= 1'b0;
            ls_q       <= WORD;
            off_q      <= 2'b00;
            wait_cnt   <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            old_q      <= '0;
            starve_cnt <= '0;
            cpu_rdata  <= '0;
            ld_rdata   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state <= next_state;
            if (!ld_req)                          starve_cnt <= '0;
            else if (state == IDLE && grant_ld)   starve_cnt <= '0;
            else if (state == IDLE && grant_cpu)  starve_cnt <= starve_cnt + SW'(1);

            if (state == IDLE && (grant_cpu || grant_ld)) begin
                id_q     <= grant_ld ? LD : CPU;
                we_q     <= g_we;
                ext_q    <= g_ext;
                ls_q     <= g_ls;
                off_q    <= g_off;
                addr_q   <= g_addr;
                wdata_q  <= grant_ld ? ld_wdata : cpu_wdata;
                mis_q    <= misalign;
                wait_cnt <= WAIT_INIT;
                if (misalign) cpu_rdata <= '0;
                if (next_state == RD) mem_addr <= g_addr;
            end

            if (state == WAIT) begin
                wait_cnt <= wait_cnt - 2'd1;
                if (wait_cnt == 2'd0) begin
                    old_q <= mem_rdata;
                    if (!we_q) begin
                        if (id_q == CPU) cpu_rdata <= extracted;
                        else             ld_rdata  <= mem_rdata;
                    end
                end
            end

            if (state == MERGE) begin
                mem_addr  <= addr_q;
                mem_wdata <= merged;
            end
        end
    end

    assign mem_en    = (state == RD) || (state == WR);
    assign mem_we    = (state == WR);
    assign cpu_done  = (state == RESP) && (id_q == CPU);
    assign ld_done   = (state == RESP) && (id_q == LD);
    assign cpu_stall = cpu_req & ~cpu_done;
`ifdef DM_ACCESS_CTRL_MISALIGN_TRAP_EN
    assign cpu_misalign = (state == RESP) && mis_q;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - self-checking bench for dm_access_ctrl with a READ_LAT-cycle SRAM model
module tb_dm_access_ctrl;

    localparam int ADDR_W = 10;
    localparam int RL     = 3;
    localparam int STARVE = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0, cpu_ext_op = 1'b0;
    logic [31:0]       cpu_addr = '0, cpu_wdata = '0;
    logic [1:0]        cpu_ls_bit = '0;
    logic [31:0]       cpu_rdata;
    logic              cpu_done, cpu_stall;
`ifdef DM_ACCESS_CTRL_MISALIGN_TRAP_EN
    logic              cpu_misalign;
`endif
    logic              ld_req = 1'b0, ld_we = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [31:0]       ld_wdata = '0;
    logic [31:0]       ld_rdata;
    logic              ld_done;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    always #5 clock = ~clock;

    dm_access_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(RL), .LD_STARVE_MAX(STARVE)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ls_bit (cpu_ls_bit),
        .cpu_ext_op (cpu_ext_op),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .cpu_stall  (cpu_stall),
`ifdef DM_ACCESS_CTRL_MISALIGN_TRAP_EN
        .cpu_misalign (cpu_misalign),
`endif
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_rdata   (ld_rdata),
        .ld_done    (ld_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // SRAM model: read data appears RL cycles after the strobe, garbage otherwise
    logic [31:0]       sram [0:(1<<ADDR_W)-1];
    logic [31:0]       rd_pipe [0:RL-1];
    int                wr_count = 0;
    int                en_count = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;

    assign mem_rdata = rd_pipe[RL-1];

    always @(posedge clock) begin
        if (mem_en) en_count <= en_count + 1;
        if (mem_en && mem_we) begin
            sram[mem_addr] <= mem_wdata;
            wr_count       <= wr_count + 1;
            last_wr_addr   <= mem_addr;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : 32'hBAD0BAD0;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        logic        chk_rdata;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  ls;
        logic        ext;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] ls, input logic ext,
                           input logic [31:0] exp);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.wdata = wdata;
        v.ls = ls; v.ext = ext; v.exp = exp;
        vecs.push_back(v);
    endtask

    function automatic int exp_lat(input logic we, input logic [1:0] ls);
        if (!we) return 2 + RL;
        if (ls == 2'b01 || ls == 2'b10) return 4 + RL;
        return 3;
    endfunction

    task automatic cpu_op(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] ls, input logic ext,
                          input logic [31:0] exp_rdata);
        exp_t e;
        int   lat;
        bit   seen;
        e.rdata = exp_rdata; e.lat = exp_lat(we, ls); e.chk_rdata = !we;
        sb.push_back(e);
        @(negedge clock);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_ls_bit = ls; cpu_ext_op = ext;
        cpu_req = 1'b1;
        lat = 0; seen = 0;
        while (!seen && lat < 60) begin
            @(negedge clock);
            lat++;
            if (cpu_done) seen = 1;
        end
        check({name, " stall"}, {31'b0, cpu_stall}, 32'd0);
        cpu_req = 1'b0;
        e = sb.pop_front();
        check({name, " done"}, {31'b0, seen}, 32'd1);
        check({name, " latency"}, lat, e.lat);
        if (e.chk_rdata) check({name, " rdata"}, cpu_rdata, e.rdata);
    endtask

    task automatic ld_op(input string name, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
        exp_t e;
        int   lat;
        bit   seen;
        e.rdata = exp_rdata; e.lat = we ? 3 : 2 + RL; e.chk_rdata = !we;
        sb.push_back(e);
        @(negedge clock);
        ld_we = we; ld_addr = addr; ld_wdata = wdata; ld_req = 1'b1;
        lat = 0; seen = 0;
        while (!seen && lat < 60) begin
            @(negedge clock);
            lat++;
            if (ld_done) seen = 1;
        end
        ld_req = 1'b0;
        e = sb.pop_front();
        check({name, " done"}, {31'b0, seen}, 32'd1);
        check({name, " latency"}, lat, e.lat);
        if (e.chk_rdata) check({name, " rdata"}, ld_rdata, e.rdata);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic sb_id[$];
        logic exp_id;
        int   n, w0, dones, en0, lat;

        repeat (3) @(negedge clock);
        check("reset cpu_done",  {31'b0, cpu_done}, 32'd0);
        check("reset ld_done",   {31'b0, ld_done},  32'd0);
        check("reset mem_en",    {31'b0, mem_en},   32'd0);
        check("reset mem_we",    {31'b0, mem_we},   32'd0);
        check("reset mem_addr",  {22'b0, mem_addr}, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset cpu_rdata", cpu_rdata, 32'd0);
        check("reset ld_rdata",  ld_rdata,  32'd0);
        check("reset cpu_stall", {31'b0, cpu_stall}, 32'd0);
        reset = 1'b0;

        cpu_op("st word", 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0);
        check("st word index", {22'b0, last_wr_addr}, 32'd4);
        check("st word sram", sram[4], 32'hDEADBEEF);

        add_vec("ld word",        1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEADBEEF);
        add_vec("st word2",       1'b1, 32'h10, 32'h11223344, 2'b00, 1'b0, 32'h0);
        add_vec("st byte",        1'b1, 32'h12, 32'h000000AA, 2'b10, 1'b0, 32'h0);
        add_vec("ld merged",      1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'h11AA3344);
        add_vec("ld byte s",      1'b0, 32'h12, 32'h0,        2'b10, 1'b1, 32'hFFFFFFAA);
        add_vec("ld byte u",      1'b0, 32'h12, 32'h0,        2'b10, 1'b0, 32'h000000AA);
        add_vec("st word3",       1'b1, 32'h10, 32'h80017FFF, 2'b00, 1'b0, 32'h0);
        add_vec("ld half hi s",   1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 32'hFFFF8001);
        add_vec("ld half lo s",   1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 32'h00007FFF);
        add_vec("ld byte3 s",     1'b0, 32'h13, 32'h0,        2'b10, 1'b1, 32'hFFFFFF80);
        add_vec("ld ls11",        1'b0, 32'h10, 32'h0,        2'b11, 1'b1, 32'h80017FFF);
        add_vec("st word5",       1'b1, 32'h14, 32'h5A5A5A5A, 2'b00, 1'b0, 32'h0);
        add_vec("st half hi",     1'b1, 32'h16, 32'h1234BEEF, 2'b01, 1'b0, 32'h0);
        add_vec("ld word5",       1'b0, 32'h14, 32'h0,        2'b00, 1'b0, 32'hBEEF5A5A);
        add_vec("ld half hi u",   1'b0, 32'h16, 32'h0,        2'b01, 1'b0, 32'h0000BEEF);
        add_vec("st byte1",       1'b1, 32'h11, 32'hFFFFFF55, 2'b10, 1'b0, 32'h0);
        add_vec("ld word4",       1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'h800155FF);
        add_vec("ld word ext",    1'b0, 32'h10, 32'h0,        2'b00, 1'b1, 32'h800155FF);

        foreach (vecs[i])
            cpu_op(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].ls, vecs[i].ext, vecs[i].exp);

        ld_op("ld_port wr", 1'b1, 10'd7, 32'hCAFEF00D, 32'h0);
        ld_op("ld_port rd", 1'b0, 10'd7, 32'h0, 32'hCAFEF00D);
        ld_op("ld_port rd5", 1'b0, 10'd5, 32'h0, 32'hBEEF5A5A);
        cpu_op("cpu sees ld", 1'b0, 32'h1C, 32'h0, 2'b00, 1'b0, 32'hCAFEF00D);

        // Both requesters held: four CPU grants, then one loader grant, repeating
        @(negedge clock);
        cpu_we = 1'b0; cpu_addr = 32'h10; cpu_ls_bit = 2'b00; cpu_ext_op = 1'b0;
        ld_we = 1'b0; ld_addr = 10'd5;
        cpu_req = 1'b1; ld_req = 1'b1;
        for (int i = 0; i < 10; i++) sb_id.push_back((i % 5) == 4);
        n = 0;
        while (sb_id.size() > 0 && n < 400) begin
            @(negedge clock);
            n++;
            if (cpu_done || ld_done) begin
                exp_id = sb_id.pop_front();
                check("starve grant order", {31'b0, ld_done}, {31'b0, exp_id});
            end
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        check("starve pending", sb_id.size(), 32'd0);

        // Reset during WAIT of a byte store: no write, no done, word unchanged
        cpu_op("pre rst st", 1'b1, 32'h10, 32'h11223344, 2'b00, 1'b0, 32'h0);
        w0 = wr_count;
        @(negedge clock);
        cpu_we = 1'b1; cpu_addr = 32'h12; cpu_wdata = 32'hAA; cpu_ls_bit = 2'b10;
        cpu_req = 1'b1;
        dones = 0;
        repeat (3) begin
            @(negedge clock);
            if (cpu_done) dones++;
        end
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clock);
        check("rst mem_en", {31'b0, mem_en}, 32'd0);
        check("rst cpu_rdata", cpu_rdata, 32'd0);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (cpu_done) dones++;
        end
        check("rst no done", dones, 32'd0);
        check("rst no write", wr_count, w0);
        check("rst word kept", sram[4], 32'h11223344);
        cpu_op("post rst st", 1'b1, 32'h12, 32'h000000AA, 2'b10, 1'b0, 32'h0);
        cpu_op("post rst ld", 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 32'h11AA3344);

`ifdef DM_ACCESS_CTRL_MISALIGN_TRAP_EN
        en0 = en_count;
        @(negedge clock);
        cpu_we = 1'b0; cpu_addr = 32'h13; cpu_ls_bit = 2'b00; cpu_ext_op = 1'b0;
        cpu_req = 1'b1;
        lat = 0;
        while (!cpu_done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("misalign latency", lat, 32'd1);
        check("misalign flag", {31'b0, cpu_misalign}, 32'd1);
        check("misalign rdata", cpu_rdata, 32'd0);
        cpu_req = 1'b0;
        repeat (3) @(negedge clock);
        check("misalign no mem_en", en_count, en0);
        check("misalign flag clear", {31'b0, cpu_misalign}, 32'd0);
`else
        en0 = 0; lat = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
